// File: rtl/frogger_input_pkg.sv
// Shared definitions for the Frogger input path: repeat FSM states, default
// timing constants and a counter width helper.
package frogger_input_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rpt_state_e;

   localparam int CLK_HZ           = 25_000_000;
   localparam int DEBOUNCE_MS      = 10;
   localparam int REPEAT_DELAY_MS  = 500;
   localparam int REPEAT_PERIOD_MS = 100;
   localparam int CYCLES_PER_MS    = CLK_HZ / 1000;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: polarity fix, 2-FF synchroniser, debounce counter,
// edge detection and hold-to-repeat FSM. Edge/repeat events are combinational.
module debounce_channel
   import frogger_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 10,
   parameter int REPEAT_PERIOD   = 3,
   parameter bit REPEAT_EN       = 1'b1,
   parameter bit INVERT          = 1'b0
) (
   input  logic i_Clk,
   input  logic i_Reset,
   input  logic i_Switch,
   output logic o_Level,
   output logic o_Rise,
   output logic o_Fall,
   output logic o_Rep
);

   localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
   localparam int RC_W = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
   localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

   logic            s1_q, s2_q;
   logic            stable_q, stable_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   rpt_state_e      state_q, state_d;
   logic [RC_W-1:0] rcnt_q, rcnt_d;
   logic            rise, fall, rep;

   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      rise     = 1'b0;
      fall     = 1'b0;
      if (s2_q == stable_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         stable_d = s2_q;
         db_cnt_d = '0;
         rise     = s2_q;
         fall     = ~s2_q;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // A release always wins over a coinciding terminal count.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rep     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise && REPEAT_EN) begin
               state_d = DELAY;
               rcnt_d  = '0;
            end
         end
         DELAY: begin
            if (fall) begin
               state_d = IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == RD_LAST) begin
               rep     = 1'b1;
               state_d = REPEAT;
               rcnt_d  = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         REPEAT: begin
            if (fall) begin
               state_d = IDLE;
               rcnt_d  = '0;
            end else if (rcnt_q == RP_LAST) begin
               rep    = 1'b1;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            rcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         db_cnt_q <= '0;
         state_q  <= IDLE;
         rcnt_q   <= '0;
      end else begin
         s1_q     <= i_Switch ^ INVERT;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         db_cnt_q <= db_cnt_d;
         state_q  <= state_d;
         rcnt_q   <= rcnt_d;
      end
   end

   assign o_Level = stable_q;
   assign o_Rise  = rise;
   assign o_Fall  = fall;
   assign o_Rep   = rep;

endmodule

// File: rtl/switch_conditioner.sv
// Conditions all push-buttons: per-channel debounce/repeat, registered edge
// pulses and a merged, optionally one-hot, move-pulse vector.
module switch_conditioner
   import frogger_input_pkg::*;
#(
   parameter int              N_CH            = 4,
   parameter int              DEBOUNCE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS,
   parameter int              REPEAT_DELAY    = CYCLES_PER_MS * REPEAT_DELAY_MS,
   parameter int              REPEAT_PERIOD   = CYCLES_PER_MS * REPEAT_PERIOD_MS,
   parameter logic [N_CH-1:0] REPEAT_MASK     = '1,
   parameter logic [N_CH-1:0] INVERT_MASK     = '0,
   parameter bit              ONE_HOT_MOVE    = 1'b1
) (
   input  logic            i_Clk,
   input  logic            i_Reset,
   input  logic [N_CH-1:0] i_Switch,
   output logic [N_CH-1:0] o_Level,
   output logic [N_CH-1:0] o_Press,
   output logic [N_CH-1:0] o_Release,
   output logic [N_CH-1:0] o_Move
);

   logic [N_CH-1:0] rise_w, fall_w, rep_w;
   logic [N_CH-1:0] raw_move, move_d;
   logic [N_CH-1:0] press_q, release_q, move_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[g]),
         .INVERT          (INVERT_MASK[g])
      ) u_ch (
         .i_Clk    (i_Clk),
         .i_Reset  (i_Reset),
         .i_Switch (i_Switch[g]),
         .o_Level  (o_Level[g]),
         .o_Rise   (rise_w[g]),
         .o_Fall   (fall_w[g]),
         .o_Rep    (rep_w[g])
      );
   end

   // Isolating the lowest set bit drops losing pulses rather than queueing them.
   always_comb begin
      raw_move = rise_w | rep_w;
      move_d   = raw_move;
      if (ONE_HOT_MOVE) begin
         move_d = raw_move & (~raw_move + N_CH'(1));
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         press_q   <= '0;
         release_q <= '0;
         move_q    <= '0;
      end else begin
         press_q   <= rise_w;
         release_q <= fall_w;
         move_q    <= move_d;
      end
   end

   assign o_Press   = press_q;
   assign o_Release = release_q;
   assign o_Move    = move_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with short timing parameters; a
// second instance with channel 0 inverted checks the active-low path.
module tb_switch_conditioner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw, sw_inv;
   logic [3:0] lvl, prs, rel, mv;
   logic [3:0] inv_lvl, inv_prs, inv_rel, inv_mv;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   switch_conditioner #(
      .N_CH(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
      .REPEAT_MASK(4'b1111), .INVERT_MASK(4'b0000), .ONE_HOT_MOVE(1'b1)
   ) dut (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw),
      .o_Level(lvl), .o_Press(prs), .o_Release(rel), .o_Move(mv)
   );

   switch_conditioner #(
      .N_CH(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3),
      .REPEAT_MASK(4'b1111), .INVERT_MASK(4'b0001), .ONE_HOT_MOVE(1'b1)
   ) dut_inv (
      .i_Clk(clk), .i_Reset(rst), .i_Switch(sw_inv),
      .o_Level(inv_lvl), .o_Press(inv_prs), .o_Release(inv_rel), .o_Move(inv_mv)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] xl, input logic [3:0] xp,
                             input logic [3:0] xr, input logic [3:0] xm);
      check_eq({tag, " level"}, {28'd0, lvl}, {28'd0, xl});
      check_eq({tag, " press"}, {28'd0, prs}, {28'd0, xp});
      check_eq({tag, " release"}, {28'd0, rel}, {28'd0, xr});
      check_eq({tag, " move"}, {28'd0, mv}, {28'd0, xm});
   endtask

   // Observe one rising edge: inputs set before the call are sampled at it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] xl, xp, xr, xm;
      rst    = 1'b1;
      sw     = 4'b0000;
      sw_inv = 4'b0000;
      repeat (3) step();
      check_outs("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      check_eq("reset inv level", {28'd0, inv_lvl}, 32'd0);
      rst = 1'b0;

      // Idle inputs; the inverted instance sees channel 0 as pressed.
      for (int e = 0; e < 50; e++) begin
         step();
         check_outs($sformatf("s1 e%0d", e), 4'b0000, 4'b0000, 4'b0000, 4'b0000);
         xl = (e >= 5) ? 4'b0001 : 4'b0000;
         xp = (e == 5) ? 4'b0001 : 4'b0000;
         xm = (e == 5 || (e >= 15 && (e - 15) % 3 == 0)) ? 4'b0001 : 4'b0000;
         check_eq($sformatf("s1 e%0d inv level", e), {28'd0, inv_lvl}, {28'd0, xl});
         check_eq($sformatf("s1 e%0d inv press", e), {28'd0, inv_prs}, {28'd0, xp});
         check_eq($sformatf("s1 e%0d inv release", e), {28'd0, inv_rel}, 32'd0);
         check_eq($sformatf("s1 e%0d inv move", e), {28'd0, inv_mv}, {28'd0, xm});
      end

      // ch0 press, repeats, release sampled at e=23.
      for (int e = 0; e <= 40; e++) begin
         sw[0] = (e <= 22);
         step();
         xl = (e >= 5 && e <= 27) ? 4'b0001 : 4'b0000;
         xp = (e == 5) ? 4'b0001 : 4'b0000;
         xr = (e == 28) ? 4'b0001 : 4'b0000;
         xm = (e inside {5, 15, 18, 21, 24, 27}) ? 4'b0001 : 4'b0000;
         check_outs($sformatf("s2 e%0d", e), xl, xp, xr, xm);
      end

      // ch1 bounces 1,1,1,0 three times, then settles high at e=12.
      for (int e = 0; e <= 35; e++) begin
         sw[1] = (e < 12) ? (e % 4 != 3) : (e <= 19);
         step();
         xl = (e >= 17 && e <= 24) ? 4'b0010 : 4'b0000;
         xp = (e == 17) ? 4'b0010 : 4'b0000;
         xr = (e == 25) ? 4'b0010 : 4'b0000;
         xm = (e == 17) ? 4'b0010 : 4'b0000;
         check_outs($sformatf("s3 e%0d", e), xl, xp, xr, xm);
      end

      // ch1 and ch3 together; ch1 released first, ch3 repeats keep going.
      for (int e = 0; e <= 40; e++) begin
         sw[1] = (e <= 15);
         sw[3] = (e <= 24);
         step();
         xl = ((e >= 5 && e <= 20) ? 4'b0010 : 4'b0000) | ((e >= 5 && e <= 29) ? 4'b1000 : 4'b0000);
         xp = (e == 5) ? 4'b1010 : 4'b0000;
         xr = (e == 21) ? 4'b0010 : ((e == 30) ? 4'b1000 : 4'b0000);
         xm = (e inside {5, 15, 18}) ? 4'b0010 : ((e inside {21, 24, 27}) ? 4'b1000 : 4'b0000);
         check_outs($sformatf("s4 e%0d", e), xl, xp, xr, xm);
      end

      // ch2 released so the debounced fall lands on a repeat terminal count.
      for (int e = 0; e <= 45; e++) begin
         sw[2] = (e <= 24);
         step();
         xl = (e >= 5 && e <= 29) ? 4'b0100 : 4'b0000;
         xp = (e == 5) ? 4'b0100 : 4'b0000;
         xr = (e == 30) ? 4'b0100 : 4'b0000;
         xm = (e inside {5, 15, 18, 21, 24, 27}) ? 4'b0100 : 4'b0000;
         check_outs($sformatf("s5 e%0d", e), xl, xp, xr, xm);
      end

      // ch0 held through a 2-cycle reset pulse in REPEAT.
      for (int e = 0; e <= 32; e++) begin
         sw[0] = 1'b1;
         rst   = (e == 19 || e == 20);
         if (e == 19) begin
            #1;
            check_eq("s6 async clear", {16'd0, lvl, prs, rel, mv}, 32'd0);
         end
         step();
         if (e < 19) begin
            xl = (e >= 5) ? 4'b0001 : 4'b0000;
            xp = (e == 5) ? 4'b0001 : 4'b0000;
            xm = (e inside {5, 15, 18}) ? 4'b0001 : 4'b0000;
         end else begin
            xl = (e >= 26) ? 4'b0001 : 4'b0000;
            xp = (e == 26) ? 4'b0001 : 4'b0000;
            xm = (e == 26) ? 4'b0001 : 4'b0000;
         end
         check_outs($sformatf("s6 e%0d", e), xl, xp, 4'b0000, xm);
         if (e >= 19) begin
            check_eq($sformatf("s6 e%0d inv level", e), {28'd0, inv_lvl}, {28'd0, xl});
            check_eq($sformatf("s6 e%0d inv press", e), {28'd0, inv_prs}, {28'd0, xp});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Parametrised successor to the per-switch debouncers in the Frogger top level.
- One instance conditions all N_CH push-buttons.
- Per channel: 2-FF synchroniser, debounce, press/release edge pulses, optional hold-to-auto-repeat.
- Merged move-pulse vector with optional one-hot arbitration feeds frog movement logic directly.

Parameters:
N_CH, 4, number of switch channels
DEBOUNCE_CYCLES, 250000, consecutive disagreeing cycles before debounced level flips (10 ms at 25 MHz); >=2
REPEAT_DELAY, 12500000, cycles from press pulse to first repeat pulse (0.5 s); >=1
REPEAT_PERIOD, 2500000, cycles between subsequent repeat pulses (0.1 s); >=1
REPEAT_MASK, 4'b1111, bit i=1 enables auto-repeat on channel i
INVERT_MASK, 4'b0000, bit i=1 treats channel i as active-low
ONE_HOT_MOVE, 1, 1 = at most one o_Move bit per cycle, lowest index wins

Ports:
i_Clk  input  1  system clock
i_Reset  input  1  asynchronous, active-high reset
i_Switch  input  N_CH  raw asynchronous switch levels
o_Level  output  N_CH  debounced, polarity-corrected level
o_Press  output  N_CH  1-cycle pulse on debounced rising edge
o_Release  output  N_CH  1-cycle pulse on debounced falling edge
o_Move  output  N_CH  1-cycle move pulses: press plus auto-repeat, after arbitration

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is asynchronous and active-high on i_Reset.
- Reset values: all outputs 0. Synchroniser flops, stable levels, counters and FSMs are cleared to 0/IDLE.
- Polarity: sample = i_Switch[i] ^ INVERT_MASK[i], taken before the synchroniser.
- Synchroniser: s1 <= sample; s2 <= s1.
- Debounce, per channel, each edge:
  - s2==stable: cnt <= 0.
  - s2!=stable and cnt==DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Otherwise: cnt++.
  - Any bounce back to stable before the terminal count clears cnt.
- Latency: if t0 is the first edge sampling a new settled level, o_Level changes at edge t0+DEBOUNCE_CYCLES+1.
- Edge pulses:
  - o_Press and o_Release are registered and assert at the same edge o_Level changes, for exactly 1 cycle.
  - They are mutually exclusive per channel.
- Repeat FSM, per channel, with counter rcnt of width clog2(max(REPEAT_DELAY, REPEAT_PERIOD)):
  - IDLE: on press, if REPEAT_MASK[i] then go to DELAY with rcnt=0.
  - DELAY: rcnt++. At rcnt==REPEAT_DELAY-1, emit rep pulse, go to REPEAT, rcnt=0.
  - REPEAT: rcnt++. At rcnt==REPEAT_PERIOD-1, emit rep pulse, rcnt=0.
  - Release in DELAY or REPEAT: go to IDLE immediately. No rep pulse that cycle, even if the terminal count coincides.
  - Channels with REPEAT_MASK[i]=0 stay in IDLE.
- Move generation: raw_move[i] = press[i] | rep[i], registered into o_Move.
  - o_Move asserts at the same edge as o_Press, and REPEAT_DELAY cycles after it for the first repeat.
- Arbitration (ONE_HOT_MOVE=1):
  - o_Move = lowest set bit of raw_move. Losing pulses are dropped, not queued.
  - Losing channels' FSMs advance normally.
  - o_Press and o_Release are never arbitrated.
- Reset mid-operation:
  - Asserting i_Reset clears everything immediately; in-flight pulses are lost.
  - If a switch is held through reset deassertion, it is treated as a new press. o_Press fires at t0+DEBOUNCE_CYCLES+1, counting from the first post-reset edge.
- Simultaneous events:
  - Channels are independent except for move arbitration.
  - A press and a rep on the same channel cannot coincide, because the FSM is in IDLE at the press.

Decomposition:
- Shared package frogger_input_pkg holds:
  - the repeat FSM state enum (IDLE, DELAY, REPEAT);
  - the default timing constants: CLK_HZ=25_000_000, DEBOUNCE_MS, REPEAT_DELAY_MS, REPEAT_PERIOD_MS;
  - a clog2-based width helper.
- Sub-module debounce_channel: synchroniser, debounce counter, edge pulses and repeat FSM for one channel.
  - It is instantiated N_CH times via generate.
  - Arbitration and output registering stay in switch_conditioner.

Test Plan:
- Sim parameters for all scenarios: N_CH=4, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset, then i_Switch=0000 held -> all outputs 0 for 50 cycles.
2. Raise ch0 at edge t0 and hold -> o_Level[0] rises and o_Press[0]=1 for 1 cycle at t0+5; o_Move[0] pulses at t0+5, t0+15, t0+18, t0+21.
3. Bounce ch1 (1 for 3 cycles, 0 for 1, repeated) -> no o_Level/o_Press activity; a final steady 1 gives o_Press 5 edges after the last rising sample.
4. Press ch1 and ch3 on the same edge -> o_Press=1010, o_Move=0010. Repeats that later coincide give only bit 1.
5. Hold ch2 into REPEAT, then release -> o_Release[2] fires at release t0+5; no further o_Move[2]; the FSM is back in IDLE.
6. Hold ch0, assert i_Reset mid-REPEAT for 2 cycles -> outputs 0 during reset; after deassertion, o_Press[0] fires 5 edges later. With INVERT_MASK=0001 and ch0 held low, o_Level[0]=1.
